// File: rtl/dit_mon_pkg.sv
// dit_mon_pkg: shared error codes, channel states and counter widths for the DIT latency monitor
package dit_mon_pkg;
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_EARLY    = 3'd1,
    ERR_LATE     = 3'd2,
    ERR_SPURIOUS = 3'd3,
    ERR_OVERLAP  = 3'd4,
    ERR_DROP     = 3'd5,
    ERR_TIMEOUT  = 3'd6
  } err_code_e;
  typedef enum logic [1:0] {IDLE, BUSY, WAIT_ACK} ch_state_e;
  localparam int ERR_CNT_W = 8;
endpackage

// File: rtl/dit_lat_channel.sv
// dit_lat_channel: per-unit handshake FSM, latency counter and sticky first-error register
module dit_lat_channel import dit_mon_pkg::*; #(
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             dit_en_i,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic             ready_i,
  input  logic [CNT_W-1:0] exp_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] lat_o,
  output logic             lat_vld_o,
  output logic             err_o,
  output logic [2:0]       err_code_o,
  output logic             ev_o
);
  ch_state_e        st;
  logic [CNT_W-1:0] cnt, exp_q;
  logic             dit_q, chk, hs, accept;
  logic             e_early, e_late, e_spur, e_ovl, e_drop, e_tmo;
  err_code_e        code;
  always_comb begin
    chk     = dit_q && exp_q != '0;
    hs      = st != IDLE && valid_i && ready_i;
    accept  = start_i && (st == IDLE || hs);
    e_early = st == BUSY && valid_i && chk && cnt < exp_q;
    e_late  = st == BUSY && !valid_i && chk && cnt == exp_q;
    e_spur  = st == IDLE && valid_i;
    e_ovl   = st != IDLE && start_i && !hs;
    e_drop  = st == WAIT_ACK && !valid_i;
    e_tmo   = st == BUSY && !valid_i && &cnt;
    code    = e_early ? ERR_EARLY : e_late ? ERR_LATE : e_spur ? ERR_SPURIOUS :
              e_ovl ? ERR_OVERLAP : e_drop ? ERR_DROP : e_tmo ? ERR_TIMEOUT : ERR_NONE;
    ev_o    = code != ERR_NONE;
  end
  assign busy_o = st != IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st         <= IDLE;
      cnt        <= '0;
      exp_q      <= '0;
      dit_q      <= 1'b0;
      lat_o      <= '0;
      lat_vld_o  <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else begin
      lat_vld_o <= st == BUSY && valid_i;
      if (st == BUSY && valid_i) lat_o <= cnt;
      if (accept) begin
        st    <= BUSY;
        cnt   <= CNT_W'(1);
        exp_q <= exp_i;
        dit_q <= dit_en_i;
      end else if (st == BUSY) begin
        st  <= valid_i ? (ready_i ? IDLE : WAIT_ACK) : (&cnt ? IDLE : BUSY);
        cnt <= cnt + 1'b1;
      end else if (st == WAIT_ACK) begin
        st <= valid_i && !ready_i ? WAIT_ACK : IDLE;
      end
      // a same-cycle error overrides the clear
      if (clr_i || (ev_o && !err_o)) begin
        err_o      <= ev_o;
        err_code_o <= code;
      end
    end
  end
endmodule

// File: rtl/dit_latency_monitor.sv
// dit_latency_monitor: multi-channel DIT latency checker with per-class expected latency and error counting
module dit_latency_monitor import dit_mon_pkg::*; #(
  parameter int NUM_CH    = 2,
  parameter int NUM_CLASS = 4,
  parameter int CNT_W     = 6,
  localparam int CLASS_W  = $clog2(NUM_CLASS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       dit_en_i,
  input  logic                       clr_i,
  input  logic [NUM_CLASS*CNT_W-1:0] exp_lat_i,
  input  logic [NUM_CH-1:0]          start_i,
  input  logic [NUM_CH*CLASS_W-1:0]  class_i,
  input  logic [NUM_CH-1:0]          valid_i,
  input  logic [NUM_CH-1:0]          ready_i,
  output logic [NUM_CH-1:0]          busy_o,
  output logic [NUM_CH*CNT_W-1:0]    lat_o,
  output logic [NUM_CH-1:0]          lat_vld_o,
  output logic [NUM_CH-1:0]          err_o,
  output logic [NUM_CH*3-1:0]        err_code_o,
  output logic [ERR_CNT_W-1:0]       err_cnt_o
);
  localparam int SUM_W = ERR_CNT_W + $clog2(NUM_CH + 1);
  logic [NUM_CH-1:0] ev;
  logic [SUM_W-1:0]  tot;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CLASS_W-1:0] cls;
    assign cls = class_i[c*CLASS_W +: CLASS_W];
    dit_lat_channel #(.CNT_W(CNT_W)) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (clr_i),
      .dit_en_i  (dit_en_i),
      .start_i   (start_i[c]),
      .valid_i   (valid_i[c]),
      .ready_i   (ready_i[c]),
      .exp_i     (exp_lat_i[cls*CNT_W +: CNT_W]),
      .busy_o    (busy_o[c]),
      .lat_o     (lat_o[c*CNT_W +: CNT_W]),
      .lat_vld_o (lat_vld_o[c]),
      .err_o     (err_o[c]),
      .err_code_o(err_code_o[c*3 +: 3]),
      .ev_o      (ev[c])
    );
  end
  always_comb begin
    tot = clr_i ? '0 : SUM_W'(err_cnt_o);
    for (int i = 0; i < NUM_CH; i++) tot = tot + SUM_W'(ev[i]);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_o <= '0;
    else err_cnt_o <= tot > SUM_W'({ERR_CNT_W{1'b1}}) ? '1 : tot[ERR_CNT_W-1:0];
  end
endmodule

// File: tb/tb_dit_latency_monitor.sv
// tb_dit_latency_monitor: directed scenario checks for the two-channel DIT latency monitor
module tb_dit_latency_monitor;
  logic        clk_i = 1'b0;
  logic        rst_i, dit_en_i, clr_i;
  logic [23:0] exp_lat_i;
  logic [1:0]  start_i, valid_i, ready_i;
  logic [3:0]  class_i;
  logic [1:0]  busy_o, lat_vld_o, err_o;
  logic [11:0] lat_o;
  logic [5:0]  err_code_o;
  logic [7:0]  err_cnt_o;
  int checks = 0;
  int errors = 0;

  dit_latency_monitor #(.NUM_CH(2), .NUM_CLASS(4), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dit_en_i(dit_en_i), .clr_i(clr_i),
    .exp_lat_i(exp_lat_i), .start_i(start_i), .class_i(class_i),
    .valid_i(valid_i), .ready_i(ready_i), .busy_o(busy_o), .lat_o(lat_o),
    .lat_vld_o(lat_vld_o), .err_o(err_o), .err_code_o(err_code_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic op_start(input int ch, input logic [1:0] cls);
    class_i[ch*2 +: 2] = cls;
    start_i[ch] = 1'b1;
    tick();
    start_i[ch] = 1'b0;
  endtask

  task automatic handshake(input int ch);
    valid_i[ch] = 1'b1;
    ready_i[ch] = 1'b1;
    tick();
    valid_i[ch] = 1'b0;
    ready_i[ch] = 1'b0;
  endtask

  task automatic clear();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
    checks++; if (busy_o !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", busy_o); end
    checks++; if (lat_o !== 12'd0) begin errors++; $display("FAIL reset_lat: got %h want 000", lat_o); end
    checks++; if ({lat_vld_o, err_o} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {lat_vld_o, err_o}); end
    checks++; if ({err_code_o, err_cnt_o} !== 14'd0) begin errors++; $display("FAIL reset_err: got %h want 0", {err_code_o, err_cnt_o}); end
    op_start(0, 2'd1);
    checks++; if (busy_o !== 2'b01) begin errors++; $display("FAIL start_busy: got %b want 01", busy_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if ({busy_o, err_o, err_cnt_o} !== 12'd0) begin errors++; $display("FAIL midop_reset: got %h want 0", {busy_o, err_o, err_cnt_o}); end
  endtask

  task automatic test_exact();
    op_start(0, 2'd1);
    tick(33);
    handshake(0);
    checks++; if (lat_o[5:0] !== 6'd34) begin errors++; $display("FAIL exact_lat: got %0d want 34", lat_o[5:0]); end
    checks++; if (lat_vld_o !== 2'b01) begin errors++; $display("FAIL exact_vld: got %b want 01", lat_vld_o); end
    checks++; if ({busy_o, err_o} !== 4'b0) begin errors++; $display("FAIL exact_state: got %b want 0000", {busy_o, err_o}); end
    tick();
    checks++; if (lat_vld_o !== 2'b00) begin errors++; $display("FAIL exact_vld_pulse: got %b want 00", lat_vld_o); end
  endtask

  task automatic test_early();
    clear();
    op_start(0, 2'd1);
    tick(19);
    handshake(0);
    checks++; if (lat_o[5:0] !== 6'd20) begin errors++; $display("FAIL early_lat: got %0d want 20", lat_o[5:0]); end
    checks++; if (err_code_o[2:0] !== 3'd1) begin errors++; $display("FAIL early_code: got %0d want 1", err_code_o[2:0]); end
    checks++; if ({err_o, err_cnt_o} !== {2'b01, 8'd1}) begin errors++; $display("FAIL early_cnt: got err %b cnt %0d want 01 1", err_o, err_cnt_o); end
  endtask

  task automatic test_late();
    clear();
    op_start(0, 2'd1);
    tick(32);
    checks++; if (err_o !== 2'b00) begin errors++; $display("FAIL late_pre33: got %b want 00", err_o); end
    tick();
    checks++; if (err_o !== 2'b00) begin errors++; $display("FAIL late_pre34: got %b want 00", err_o); end
    tick();
    checks++; if ({err_code_o[2:0], err_cnt_o} !== {3'd2, 8'd1}) begin errors++; $display("FAIL late_raise: got code %0d cnt %0d want 2 1", err_code_o[2:0], err_cnt_o); end
    tick(5);
    handshake(0);
    checks++; if (lat_o[5:0] !== 6'd40) begin errors++; $display("FAIL late_lat: got %0d want 40", lat_o[5:0]); end
    checks++; if ({err_code_o[2:0], err_cnt_o} !== {3'd2, 8'd1}) begin errors++; $display("FAIL late_once: got code %0d cnt %0d want 2 1", err_code_o[2:0], err_cnt_o); end
  endtask

  task automatic test_no_dit();
    clear();
    dit_en_i = 1'b0;
    op_start(0, 2'd1);
    tick(19);
    handshake(0);
    checks++; if ({lat_o[5:0], err_o} !== {6'd20, 2'b00}) begin errors++; $display("FAIL nodit_early: got lat %0d err %b want 20 00", lat_o[5:0], err_o); end
    op_start(0, 2'd1);
    tick(62);
    checks++; if ({busy_o, err_o} !== 4'b0100) begin errors++; $display("FAIL nodit_wait: got %b want 0100", {busy_o, err_o}); end
    tick();
    checks++; if (busy_o !== 2'b00) begin errors++; $display("FAIL timeout_busy: got %b want 00", busy_o); end
    checks++; if ({err_code_o[2:0], err_cnt_o} !== {3'd6, 8'd1}) begin errors++; $display("FAIL timeout_code: got code %0d cnt %0d want 6 1", err_code_o[2:0], err_cnt_o); end
    dit_en_i = 1'b1;
  endtask

  task automatic test_spur_overlap();
    clear();
    valid_i[1] = 1'b1;
    tick();
    valid_i[1] = 1'b0;
    checks++; if ({err_o, err_code_o[5:3], err_cnt_o} !== {2'b10, 3'd3, 8'd1}) begin errors++; $display("FAIL spurious: got err %b code %0d cnt %0d want 10 3 1", err_o, err_code_o[5:3], err_cnt_o); end
    clear();
    op_start(0, 2'd1);
    op_start(0, 2'd1);
    checks++; if ({busy_o, err_code_o[2:0], err_cnt_o} !== {2'b01, 3'd4, 8'd1}) begin errors++; $display("FAIL overlap: got busy %b code %0d cnt %0d want 01 4 1", busy_o, err_code_o[2:0], err_cnt_o); end
    clear();
    start_i[0] = 1'b1;
    valid_i[1] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    valid_i[1] = 1'b0;
    checks++; if ({err_o, err_code_o, err_cnt_o} !== {2'b11, 6'b011_100, 8'd2}) begin errors++; $display("FAIL dual_event: got err %b code %b cnt %0d want 11 011100 2", err_o, err_code_o, err_cnt_o); end
    handshake(0);
  endtask

  task automatic test_drop_clr();
    clear();
    op_start(0, 2'd2);
    tick(2);
    valid_i[0] = 1'b1;
    tick();
    checks++; if ({busy_o, err_o} !== 4'b0100) begin errors++; $display("FAIL wait_ack: got %b want 0100", {busy_o, err_o}); end
    tick(2);
    checks++; if ({busy_o, err_o} !== 4'b0100) begin errors++; $display("FAIL wait_hold: got %b want 0100", {busy_o, err_o}); end
    valid_i[0] = 1'b0;
    tick();
    checks++; if ({busy_o, err_code_o[2:0], err_cnt_o} !== {2'b00, 3'd5, 8'd1}) begin errors++; $display("FAIL drop: got busy %b code %0d cnt %0d want 00 5 1", busy_o, err_code_o[2:0], err_cnt_o); end
    clr_i = 1'b1;
    valid_i[1] = 1'b1;
    tick();
    clr_i = 1'b0;
    valid_i[1] = 1'b0;
    checks++; if ({err_o, err_code_o, err_cnt_o} !== {2'b10, 6'b011_000, 8'd1}) begin errors++; $display("FAIL clr_vs_err: got err %b code %b cnt %0d want 10 011000 1", err_o, err_code_o, err_cnt_o); end
  endtask

  task automatic test_back_to_back();
    clear();
    op_start(0, 2'd3);
    tick(9);
    start_i[0] = 1'b1;
    handshake(0);
    start_i[0] = 1'b0;
    checks++; if ({lat_o[5:0], lat_vld_o, busy_o, err_o} !== {6'd10, 2'b01, 2'b01, 2'b00}) begin errors++; $display("FAIL b2b_first: got lat %0d vld %b busy %b err %b want 10 01 01 00", lat_o[5:0], lat_vld_o, busy_o, err_o); end
    tick(9);
    handshake(0);
    checks++; if ({lat_o[5:0], lat_vld_o, busy_o, err_o} !== {6'd10, 2'b01, 2'b00, 2'b00}) begin errors++; $display("FAIL b2b_second: got lat %0d vld %b busy %b err %b want 10 01 00 00", lat_o[5:0], lat_vld_o, busy_o, err_o); end
  endtask

  task automatic test_saturate();
    clear();
    valid_i = 2'b11;
    tick(127);
    checks++; if (err_cnt_o !== 8'd254) begin errors++; $display("FAIL sat_pre: got %0d want 254", err_cnt_o); end
    tick();
    checks++; if (err_cnt_o !== 8'd255) begin errors++; $display("FAIL sat_clamp: got %0d want 255", err_cnt_o); end
    tick();
    checks++; if (err_cnt_o !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", err_cnt_o); end
    valid_i = 2'b00;
    clear();
    checks++; if ({err_o, err_cnt_o} !== 10'd0) begin errors++; $display("FAIL sat_clear: got err %b cnt %0d want 00 0", err_o, err_cnt_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    dit_en_i = 1'b1;
    clr_i = 1'b0;
    exp_lat_i = {6'd10, 6'd0, 6'd34, 6'd5};
    start_i = '0;
    valid_i = '0;
    ready_i = '0;
    class_i = '0;
    test_reset();
    test_exact();
    test_early();
    test_late();
    test_no_dit();
    test_spur_overlap();
    test_drop_clr();
    test_back_to_back();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dit_latency_monitor.md
Name: dit_latency_monitor

Overview:
Synthesizable, multi-channel latency checker for data-independent-timing (DIT) execution units such as multdiv and future crypto units. Each channel tracks one unit's start/valid/ready handshake and measures issue-to-valid latency in cycles. In DIT mode it compares that latency against a per-operation-class expected value and flags early, late, spurious, overlapping, dropped and timed-out results. It sits beside the units in the core and feeds the debug/alert path; it is also reused as the checker in the formal DIT harnesses.

Parameters:
NUM_CH, 2, number of monitored units (channels), >=1
NUM_CLASS, 4, number of operation classes with distinct expected latency, >=2
CNT_W, 6, latency counter width; counter saturates at 2^CNT_W-1
CLASS_W, $clog2(NUM_CLASS), derived; not overridden

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
dit_en_i  in  1  DIT checking enable; sampled per channel at start
clr_i  in  1  clears sticky error state and err_cnt_o
exp_lat_i  in  NUM_CLASS*CNT_W  expected latency of class k at [k*CNT_W +: CNT_W]; 0 = unchecked; static while any channel busy
start_i  in  NUM_CH  operation issued on channel c
class_i  in  NUM_CH*CLASS_W  class of the issued op, valid with start_i
valid_i  in  NUM_CH  unit result valid
ready_i  in  NUM_CH  consumer ready; handshake when valid_i&ready_i
busy_o  out  NUM_CH  channel in BUSY or WAIT_ACK
lat_o  out  NUM_CH*CNT_W  last measured latency per channel
lat_vld_o  out  NUM_CH  1-cycle pulse when lat_o updates
err_o  out  NUM_CH  sticky error flag per channel
err_code_o  out  NUM_CH*3  first error code since reset/clear per channel
err_cnt_o  out  8  total error events, saturating at 255

Behaviour:
- Reset (rst_i=1 at a clock edge): every channel -> IDLE; all outputs 0. Reset mid-operation abandons the operation silently (no error).
- Latency: the start cycle is cycle 0; cnt=1 in the following cycle and increments each cycle in BUSY. Valid seen at cnt=c gives latency c.
- Per-channel FSM:
  - IDLE:
    - start_i -> BUSY; latch class, exp=exp_lat_i[class] and dit=dit_en_i.
    - valid_i in IDLE -> SPURIOUS. A start in the same cycle is still accepted.
  - BUSY:
    - valid_i at cnt=c: lat_o<=c; lat_vld_o pulses next cycle.
    - If dit and exp!=0 and c<exp -> EARLY. If c>exp, LATE was already raised.
    - Then: ready_i -> IDLE; otherwise -> WAIT_ACK.
    - No valid_i while dit, exp!=0 and cnt==exp -> LATE, raised once. Stay BUSY to measure the true latency.
    - cnt reaching all-ones without valid -> TIMEOUT and -> IDLE.
  - WAIT_ACK:
    - valid_i must stay high until ready_i; valid&ready -> IDLE.
    - !valid_i -> DROP and -> IDLE.
  - Start in BUSY or WAIT_ACK -> OVERLAP; the start is ignored.
  - Exception: a start in the same cycle as a completing handshake (valid&ready in BUSY or WAIT_ACK) is accepted back-to-back -> BUSY.
- dit=0: EARLY/LATE suppressed; SPURIOUS, OVERLAP, DROP and TIMEOUT remain active; lat_o is still reported.
- Error codes:
  - 0 NONE, 1 EARLY, 2 LATE, 3 SPURIOUS, 4 OVERLAP, 5 DROP, 6 TIMEOUT.
  - Several codes on one channel in one cycle: the lowest code is recorded, and it counts as one event.
- Error outputs:
  - err_o and err_code_o are set on the first error and hold; later errors do not overwrite err_code_o.
  - err_cnt_o adds the number of channels with an error event that cycle, saturating.
  - clr_i zeroes err_o, err_code_o and err_cnt_o. An error in the same cycle as clr_i wins: it is recorded after the clear, so the count becomes that cycle's events.
- Registered outputs: all outputs are registered; errors are visible the cycle after the triggering edge.

Decomposition:
- Package dit_mon_pkg: err_code_e (3-bit enum above), ch_state_e (IDLE/BUSY/WAIT_ACK), ERR_CNT_W=8.
- Sub-module dit_lat_channel: FSM, counter, latched class/exp/dit, per-channel error register; emits an error-event strobe.
- Top: generate loop over NUM_CH, exp_lat_i class mux, saturating popcount accumulator for err_cnt_o.

Test Plan:
- exp class1=34, dit_en_i=1, start ch0 class1, valid&ready at cnt=34 -> lat_o=34, lat_vld_o pulse, err_o=0.
- Same setup with valid at cnt=20 -> err_code_o[ch0]=1 (EARLY), err_cnt_o=1, lat_o=20.
- Same setup with valid at cnt=40 -> LATE raised the cycle after cnt=34, lat_o=40, err_cnt_o=1, no second error.
- dit_en_i=0, valid at cnt=20 -> no error; no valid for 63 cycles -> TIMEOUT(6), busy_o falls.
- ch1: valid_i with no start -> SPURIOUS(3). ch0: start during BUSY -> OVERLAP(4). Same cycle as both -> err_cnt_o +=2.
- ch0 valid held 3 cycles with ready_i=0, then valid drops -> DROP(5). clr_i with a simultaneous new error -> err_cnt_o=1, err_o=1.
